// File: rtl/video_crop_hv.sv
// video_crop_hv: measures active width/height of the incoming frame, gates DE
// to a centred, offsettable HCROP_SIZE x VCROP_SIZE window and recomputes the
// output aspect ratio from both crop factors with a sequential normalising shifter.
module video_crop_hv #(
    parameter int HW   = 12,
    parameter int VW   = 10,
    parameter int ARW  = 12,
    parameter int OFFW = 5
) (
    input  logic            CLK_VIDEO,
    input  logic            RESET_N,
    input  logic            CE_PIXEL,
    input  logic            VGA_VS,
    input  logic            VGA_DE_IN,
    input  logic [ARW-1:0]  ARX,
    input  logic [ARW-1:0]  ARY,
    input  logic [HW-1:0]   HCROP_SIZE,
    input  logic [VW-1:0]   VCROP_SIZE,
    input  logic [OFFW-1:0] HCROP_OFF,
    input  logic [OFFW-1:0] VCROP_OFF,
    output logic            VGA_DE,
    output logic [ARW-1:0]  VIDEO_ARX,
    output logic [ARW-1:0]  VIDEO_ARY,
    output logic            AR_BUSY
);

    localparam int P  = ARW + HW + VW;
    localparam int MW = (HW > VW) ? HW : VW;

    typedef enum logic [1:0] {IDLE, MUL, NORM} ar_state_t;

    ar_state_t      state;
    ar_state_t      state_nxt;

    logic           de_d;
    logic           vs_d;
    logic           vs_rise;
    logic           de_fall;
    logic           ar_start;

    logic [HW-1:0]  hcpt;
    logic [HW-1:0]  hline;
    logic [HW-1:0]  hsize;
    logic [HW-1:0]  hcrop;
    logic [HW-1:0]  hoff;
    logic [VW-1:0]  vcpt;
    logic [VW-1:0]  vsize;
    logic [VW-1:0]  vcrop;
    logic [VW-1:0]  voff;
    logic [MW-1:0]  hoff_nxt;
    logic [MW-1:0]  voff_nxt;

    logic           vde;
    logic           hde;

    logic           ar_pass;
    logic [HW-1:0]  hf;
    logic [VW-1:0]  vf;
    logic [P-1:0]   px_mul;
    logic [P-1:0]   py_mul;
    logic [P-1:0]   px;
    logic [P-1:0]   py;
    logic           load_mul;
    logic           do_shift;
    logic           load_out;
    logic           track;

    // Window start for one axis: centre the window (floor), move it by the
    // signed offset, and saturate so the window stays inside the measured size.
    function automatic logic [MW-1:0] crop_off(input logic [MW-1:0]   size,
                                               input logic [MW-1:0]   crop,
                                               input logic [OFFW-1:0] off);
        logic signed [MW+1:0] s;
        logic signed [MW+1:0] c;
        logic signed [MW+1:0] o;
        logic signed [MW+1:0] adj;
        logic signed [MW+1:0] half;
        logic signed [MW+1:0] room;
        logic        [MW-1:0] r;
        s    = $signed({2'b00, size});
        c    = $signed({2'b00, crop});
        o    = $signed({{(MW + 2 - OFFW){off[OFFW-1]}}, off});
        room = s - c;
        adj  = room + (o <<< 1);
        half = adj >>> 1;
        if (adj < 0) begin
            r = '0;
        end else if (half + c > s) begin
            r = room[MW-1:0];
        end else begin
            r = half[MW-1:0];
        end
        return r;
    endfunction

    assign vs_rise = CE_PIXEL & VGA_VS & ~vs_d;
    assign de_fall = CE_PIXEL & de_d & ~VGA_DE_IN;

    // Pixel/line counting, frame size capture and crop latching at VS rise.
    always_ff @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            de_d     <= 1'b0;
            vs_d     <= 1'b0;
            ar_start <= 1'b0;
            hcpt     <= '0;
            hline    <= '0;
            hsize    <= '0;
            hcrop    <= '0;
            vcpt     <= '0;
            vsize    <= '0;
            vcrop    <= '0;
        end else begin
            ar_start <= vs_rise;
            if (CE_PIXEL) begin
                de_d <= VGA_DE_IN;
                vs_d <= VGA_VS;
                if (VGA_DE_IN) begin
                    hcpt <= hcpt + 1'b1;
                end
                if (de_fall) begin
                    hline <= hcpt;
                    hcpt  <= '0;
                    vcpt  <= vcpt + 1'b1;
                end
                if (vs_rise) begin
                    vsize <= vcpt;
                    hsize <= hline;
                    vcpt  <= '0;
                    vcrop <= (VCROP_SIZE == '0 || VCROP_SIZE >= vcpt)  ? '0 : VCROP_SIZE;
                    hcrop <= (HCROP_SIZE == '0 || HCROP_SIZE >= hline) ? '0 : HCROP_SIZE;
                end
            end
        end
    end

    assign hoff_nxt = crop_off(MW'(hsize), MW'(hcrop), HCROP_OFF);
    assign voff_nxt = crop_off(MW'(vsize), MW'(vcrop), VCROP_OFF);

    // Window start positions, recomputed every clock from the latched sizes.
    always_ff @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            hoff <= '0;
            voff <= '0;
        end else begin
            hoff <= hoff_nxt[HW-1:0];
            voff <= voff_nxt[VW-1:0];
        end
    end

    // Vertical window enable for the current line.
    always_ff @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            vde <= 1'b0;
        end else begin
            vde <= (vcrop == '0) ||
                   (({1'b0, vcpt} >= {1'b0, voff}) &&
                    ({1'b0, vcpt} <  ({1'b0, voff} + {1'b0, vcrop})));
        end
    end

    assign hde = (hcrop == '0) ||
                 (({1'b0, hcpt} >= {1'b0, hoff}) &&
                  ({1'b0, hcpt} <  ({1'b0, hoff} + {1'b0, hcrop})));

    assign VGA_DE = vde & hde & VGA_DE_IN;

    assign ar_pass = (hcrop == '0 && vcrop == '0) || (ARY == '0) ||
                     (hsize == '0) || (vsize == '0);
    assign hf      = (hcrop != '0) ? hcrop : hsize;
    assign vf      = (vcrop != '0) ? vcrop : vsize;
    assign px_mul  = P'(ARX) * P'(hf) * P'(vsize);
    assign py_mul  = P'(ARY) * P'(vf) * P'(hsize);
    assign AR_BUSY = (state != IDLE);

    // AR state register.
    always_ff @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // AR next state and datapath controls; a new frame restarts the calculation.
    always_comb begin
        state_nxt = state;
        load_mul  = 1'b0;
        do_shift  = 1'b0;
        load_out  = 1'b0;
        track     = 1'b0;
        case (state)
            IDLE: begin
                track = ar_pass;
            end
            MUL: begin
                load_mul  = 1'b1;
                state_nxt = (px_mul == '0 && py_mul == '0) ? IDLE : NORM;
            end
            NORM: begin
                if (px[P-1] | py[P-1]) begin
                    load_out  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    do_shift = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (ar_start) begin
            state_nxt = ar_pass ? IDLE : MUL;
            load_out  = 1'b0;
        end
    end

    // Product registers, normalising shift and aspect outputs.
    always_ff @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            px        <= '0;
            py        <= '0;
            VIDEO_ARX <= '0;
            VIDEO_ARY <= '0;
        end else begin
            if (load_mul) begin
                px <= px_mul;
                py <= py_mul;
            end else if (do_shift) begin
                px <= {px[P-2:0], 1'b0};
                py <= {py[P-2:0], 1'b0};
            end
            if (load_out) begin
                VIDEO_ARX <= px[P-1:P-ARW];
                VIDEO_ARY <= py[P-1:P-ARW];
            end else if (track) begin
                VIDEO_ARX <= ARX;
                VIDEO_ARY <= ARY;
            end
        end
    end

endmodule

// File: tb/tb_video_crop_hv.sv
// Testbench for video_crop_hv: drives small frames with a random pixel enable
// and compares cropped DE and aspect outputs against a frame-level model.
module tb_video_crop_hv;

    localparam int HW   = 12;
    localparam int VW   = 10;
    localparam int ARW  = 12;
    localparam int OFFW = 5;

    logic            CLK_VIDEO;
    logic            RESET_N;
    logic            CE_PIXEL;
    logic            VGA_VS;
    logic            VGA_DE_IN;
    logic [ARW-1:0]  ARX;
    logic [ARW-1:0]  ARY;
    logic [HW-1:0]   HCROP_SIZE;
    logic [VW-1:0]   VCROP_SIZE;
    logic [OFFW-1:0] HCROP_OFF;
    logic [OFFW-1:0] VCROP_OFF;
    logic            VGA_DE;
    logic [ARW-1:0]  VIDEO_ARX;
    logic [ARW-1:0]  VIDEO_ARY;
    logic            AR_BUSY;

    video_crop_hv #(.HW(HW), .VW(VW), .ARW(ARW), .OFFW(OFFW)) dut (
        .CLK_VIDEO  (CLK_VIDEO),
        .RESET_N    (RESET_N),
        .CE_PIXEL   (CE_PIXEL),
        .VGA_VS     (VGA_VS),
        .VGA_DE_IN  (VGA_DE_IN),
        .ARX        (ARX),
        .ARY        (ARY),
        .HCROP_SIZE (HCROP_SIZE),
        .VCROP_SIZE (VCROP_SIZE),
        .HCROP_OFF  (HCROP_OFF),
        .VCROP_OFF  (VCROP_OFF),
        .VGA_DE     (VGA_DE),
        .VIDEO_ARX  (VIDEO_ARX),
        .VIDEO_ARY  (VIDEO_ARY),
        .AR_BUSY    (AR_BUSY)
    );

    initial CLK_VIDEO = 1'b0;
    always #5 CLK_VIDEO = ~CLK_VIDEO;

    int   n_chk  = 0;
    int   n_pass = 0;
    bit   busy_seen;
    int   prev_w = 0;
    int   prev_h = 0;
    logic [ARW-1:0] m_arx = '0;
    logic [ARW-1:0] m_ary = '0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: drive at the falling edge, sample shortly after.
    task automatic cyc(input logic ce, input logic de, input logic vs, output logic obs);
        @(negedge CLK_VIDEO);
        CE_PIXEL  = ce;
        VGA_DE_IN = de;
        VGA_VS    = vs;
        #1;
        obs = VGA_DE;
        if (AR_BUSY) busy_seen = 1'b1;
    endtask

    // One pixel: random idle clocks with CE low, then the enabled clock.
    task automatic pix(input logic de, input logic vs, output logic obs);
        logic o;
        while ($urandom_range(3) == 0) cyc(1'b0, de, vs, o);
        cyc(1'b1, de, vs, obs);
    endtask

    // Window start: floor-centred, shifted by the offset, kept inside the frame.
    function automatic int offm(input int size, input int crop, input int off);
        int d;
        int o;
        d = size - crop;
        o = d / 2 + off;
        if (o < 0) o = 0;
        if (o > d) o = d;
        return o;
    endfunction

    // Expected aspect: cross-multiplied crop factors, scaled so the larger
    // product's leading one sits at the top bit of an ARW-wide result.
    task automatic ar_model(input int hsz, input int vsz, input int hc, input int vc,
                            output bit pass);
        longint px;
        longint py;
        longint u;
        int     m;
        pass = (hc == 0 && vc == 0) || (ARY == 0) || (hsz == 0) || (vsz == 0);
        if (pass) begin
            m_arx = ARX;
            m_ary = ARY;
            return;
        end
        px = longint'(ARX) * longint'((hc != 0) ? hc : hsz) * longint'(vsz);
        py = longint'(ARY) * longint'((vc != 0) ? vc : vsz) * longint'(hsz);
        u  = px | py;
        if (u == 0) return;
        m = 0;
        for (int b = 0; b < 40; b++) if (((u >> b) & 1) != 0) m = b;
        if (m >= ARW - 1) begin
            m_arx = ARW'(px >> (m - (ARW - 1)));
            m_ary = ARW'(py >> (m - (ARW - 1)));
        end else begin
            m_arx = ARW'(px << ((ARW - 1) - m));
            m_ary = ARW'(py << ((ARW - 1) - m));
        end
    endtask

    task automatic frame(input int w, input int h, input bit do_rst);
        int hc;
        int vc;
        int ho;
        int vo;
        int k;
        bit pass;
        logic o;
        logic [63:0] om;
        logic [63:0] em;
        hc = (HCROP_SIZE == 0 || int'(HCROP_SIZE) >= prev_w) ? 0 : int'(HCROP_SIZE);
        vc = (VCROP_SIZE == 0 || int'(VCROP_SIZE) >= prev_h) ? 0 : int'(VCROP_SIZE);
        ho = offm(prev_w, hc, int'($signed(HCROP_OFF)));
        vo = offm(prev_h, vc, int'($signed(VCROP_OFF)));
        ar_model(prev_w, prev_h, hc, vc, pass);
        busy_seen = 1'b0;
        pix(1'b0, 1'b1, o);
        pix(1'b0, 1'b1, o);
        for (int i = 0; i < 6; i++) pix(1'b0, 1'b0, o);
        if (do_rst) begin
            k = 0;
            while (!AR_BUSY && k < 60) begin
                cyc(1'b0, 1'b0, 1'b0, o);
                k++;
            end
            chk("busy_before_rst", AR_BUSY, 1);
            cyc(1'b0, 1'b0, 1'b0, o);
            cyc(1'b0, 1'b0, 1'b0, o);
            RESET_N = 1'b0;
            cyc(1'b0, 1'b1, 1'b0, o);
            RESET_N = 1'b1;
            chk("rst_norm_de", o, 0);
            chk("rst_norm_arx", VIDEO_ARX, 0);
            chk("rst_norm_ary", VIDEO_ARY, 0);
            chk("rst_norm_busy", AR_BUSY, 0);
            hc = 0;
            vc = 0;
            ar_model(0, 0, 0, 0, pass);
            for (int i = 0; i < 6; i++) pix(1'b0, 1'b0, o);
        end
        for (int y = 0; y < h; y++) begin
            om = '0;
            em = '0;
            for (int x = 0; x < w; x++) begin
                pix(1'b1, 1'b0, o);
                om[x] = o;
                em[x] = (hc == 0 || (x >= ho && x < ho + hc)) &&
                        (vc == 0 || (y >= vo && y < vo + vc));
            end
            for (int i = 0; i < 4; i++) pix(1'b0, 1'b0, o);
            chk($sformatf("de_line%0d", y), longint'(om), longint'(em));
        end
        for (int i = 0; i < 3; i++) pix(1'b0, 1'b0, o);
        chk("arx", VIDEO_ARX, m_arx);
        chk("ary", VIDEO_ARY, m_ary);
        chk("busy_end", AR_BUSY, 0);
        if (!do_rst) chk("busy_seen", busy_seen, pass ? 0 : 1);
        prev_w = w;
        prev_h = h;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic o;
        int   w;
        int   h;
        RESET_N    = 1'b0;
        CE_PIXEL   = 1'b0;
        VGA_VS     = 1'b0;
        VGA_DE_IN  = 1'b0;
        ARX        = 12'd4;
        ARY        = 12'd3;
        HCROP_SIZE = '0;
        VCROP_SIZE = '0;
        HCROP_OFF  = '0;
        VCROP_OFF  = '0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, o);
        chk("rst_de", o, 0);
        chk("rst_arx", VIDEO_ARX, 0);
        chk("rst_ary", VIDEO_ARY, 0);
        chk("rst_busy", AR_BUSY, 0);
        RESET_N = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, o);

        frame(32, 30, 0);
        frame(32, 30, 0);

        VCROP_SIZE = 10'd28;
        frame(32, 30, 0);
        VCROP_OFF = 5'sd15;
        frame(32, 30, 0);
        VCROP_OFF = -5'sd15;
        frame(32, 30, 0);

        VCROP_OFF  = '0;
        VCROP_SIZE = '0;
        HCROP_SIZE = 12'd30;
        frame(32, 30, 0);

        HCROP_SIZE = '0;
        VCROP_SIZE = 10'd30;
        frame(32, 30, 0);
        VCROP_SIZE = 10'd300;
        frame(32, 30, 0);

        VCROP_SIZE = 10'd28;
        frame(32, 30, 0);
        frame(32, 30, 1);
        frame(32, 30, 0);

        for (int i = 0; i < 12; i++) begin
            w = $urandom_range(8, 40);
            h = $urandom_range(6, 30);
            HCROP_SIZE = ($urandom_range(0, 2) == 0) ? '0 : HW'($urandom_range(1, 44));
            VCROP_SIZE = ($urandom_range(0, 2) == 0) ? '0 : VW'($urandom_range(1, 34));
            HCROP_OFF  = OFFW'($urandom);
            VCROP_OFF  = OFFW'($urandom);
            ARX        = ARW'($urandom_range(1, 4095));
            ARY        = ($urandom_range(0, 5) == 0) ? '0 : ARW'($urandom_range(1, 4095));
            frame(w, h, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
